player_motion_ctrl: RTL and testbench

PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

---
 rtl/game_pkg.sv | 29 ++
 rtl/player_motion_ctrl_ramp.sv | 51 +++++
 rtl/player_motion_ctrl.sv | 142 ++++++++++++++
 tb/tb_player_motion_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and default playfield constants for the player motion controller.
package game_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCEL   = 2'd1;
  localparam logic [1:0] ST_CRUISE  = 2'd2;
  localparam logic [1:0] ST_BLOCKED = 2'd3;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_L    = 2'd1,
    DIR_R    = 2'd2
  } dir_t;

  localparam int DEF_POS_W       = 10;
  localparam int DEF_X_MAX       = 240;
  localparam int DEF_PLAYER_W    = 24;
  localparam int DEF_START_POS   = 108;
  localparam int DEF_MAX_SPEED   = 4;
  localparam int DEF_ACCEL_TICKS = 8;

  // Pressing both buttons cancels out, same as pressing none.
  function automatic dir_t decode_dir(input logic left, input logic right);
    if (left && !right) return DIR_L;
    if (right && !left) return DIR_R;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/player_motion_ctrl_ramp.sv
// motion_ramp: held-tick counter n and the speed it implies for the current tick.
module motion_ramp
  import game_pkg::*;
#(
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int ACCEL_TICKS = DEF_ACCEL_TICKS
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tick,
  input  logic                             restart,
  input  logic                             hold,
  output logic [$clog2(MAX_SPEED+1)-1:0]   speed
);

  localparam int SPD_W = $clog2(MAX_SPEED + 1);
  // n stops at the first count that yields MAX_SPEED.
  localparam int N_SAT = (MAX_SPEED - 1) * ACCEL_TICKS + 1;
  localparam int N_W   = $clog2(N_SAT + 1);

  logic [N_W-1:0] n;
  logic [N_W-1:0] n_next;
  logic [31:0]    step;

  always_comb begin
    n_next = '0;
    if (restart)
      n_next = N_W'(1);
    else if (hold)
      n_next = (n >= N_W'(N_SAT)) ? n : n + N_W'(1);
  end

  // Speed reflects n_next so the position can move on the same tick.
  always_comb begin
    step = 32'(n_next - N_W'(1)) / 32'(ACCEL_TICKS);
    if (n_next == '0)
      speed = '0;
    else if (step + 32'd1 >= 32'(MAX_SPEED))
      speed = SPD_W'(MAX_SPEED);
    else
      speed = SPD_W'(step + 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      n <= '0;
    else if (tick)
      n <= n_next;
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player sprite horizontal motion: direction FSM plus clamped position datapath.
// Build option: PLAYER_MOTION_WRAP_EN wraps the position around the playfield instead of clamping.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int POS_W       = DEF_POS_W,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int PLAYER_W    = DEF_PLAYER_W,
  parameter int START_POS   = DEF_START_POS,
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int ACCEL_TICKS = DEF_ACCEL_TICKS
)(
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic                             i_fTick,
  input  logic                             i_Btn_Left,
  input  logic                             i_Btn_Right,
  output logic [POS_W-1:0]                 o_Player_Position,
  output logic [$clog2(MAX_SPEED+1)-1:0]   o_Speed,
  output logic                             o_Moving,
  output logic                             o_Wall_Hit
);
  // state   | meaning
  // IDLE    | no direction held, speed 0
  // ACCEL   | moving, speed still ramping up
  // CRUISE  | moving at MAX_SPEED
  // BLOCKED | pinned at a wall while the same direction is held

  localparam int SPD_W = $clog2(MAX_SPEED + 1);
  localparam int EXT_W = POS_W + 2;
  localparam logic signed [EXT_W-1:0] POS_LIM   = EXT_W'(X_MAX - PLAYER_W);
  localparam logic signed [EXT_W-1:0] POS_RANGE = EXT_W'(X_MAX - PLAYER_W + 1);

  if (MAX_SPEED < 1 || ACCEL_TICKS < 1 || START_POS > X_MAX - PLAYER_W ||
      X_MAX >= 2**POS_W) begin : g_param_check
    $error("player_motion_ctrl: illegal parameter combination");
  end

  logic [1:0]              state, state_next;
  dir_t                    dir, last_dir;
  logic                    moving, restart, hold, advance, clamp;
  logic [SPD_W-1:0]        ramp_speed, speed_next;
  logic signed [EXT_W-1:0] pos_ext, spd_ext, pos_sum;
  logic [POS_W-1:0]        pos_new, pos_next;

  motion_ramp #(
    .MAX_SPEED   (MAX_SPEED),
    .ACCEL_TICKS (ACCEL_TICKS)
  ) u_ramp (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .tick    (i_fTick),
    .restart (restart),
    .hold    (hold),
    .speed   (ramp_speed)
  );

  assign moving   = (state == ST_ACCEL) || (state == ST_CRUISE);
  assign o_Moving = moving;
  assign advance  = restart | hold;

  // Reversal or leaving IDLE/BLOCKED starts a fresh ramp; BLOCKED with the same direction stays put.
  always_comb begin
    dir     = decode_dir(i_Btn_Left, i_Btn_Right);
    restart = 1'b0;
    hold    = 1'b0;
    if (dir != DIR_NONE) begin
      if (moving && dir == last_dir)
        hold = 1'b1;
      else if (!(state == ST_BLOCKED && dir == last_dir))
        restart = 1'b1;
    end
  end

  always_comb begin
    pos_ext = $signed({2'b00, o_Player_Position});
    spd_ext = $signed(EXT_W'(ramp_speed));
    pos_sum = (dir == DIR_L) ? pos_ext - spd_ext : pos_ext + spd_ext;
    clamp   = 1'b0;
`ifdef PLAYER_MOTION_WRAP_EN
    if (pos_sum[EXT_W-1])
      pos_new = POS_W'(pos_sum + POS_RANGE);
    else if (pos_sum >= POS_RANGE)
      pos_new = POS_W'(pos_sum - POS_RANGE);
    else
      pos_new = POS_W'(pos_sum);
`else
    if (pos_sum[EXT_W-1]) begin
      clamp   = 1'b1;
      pos_new = '0;
    end else if (pos_sum > POS_LIM) begin
      clamp   = 1'b1;
      pos_new = POS_W'(POS_LIM);
    end else begin
      pos_new = POS_W'(pos_sum);
    end
`endif
  end

  always_comb begin
    state_next = state;
    speed_next = '0;
    pos_next   = o_Player_Position;
    if (dir == DIR_NONE) begin
      state_next = ST_IDLE;
    end else if (advance) begin
      pos_next = pos_new;
      if (clamp) begin
        state_next = ST_BLOCKED;
      end else begin
        state_next = (ramp_speed == SPD_W'(MAX_SPEED)) ? ST_CRUISE : ST_ACCEL;
        speed_next = ramp_speed;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state             <= ST_IDLE;
      last_dir          <= DIR_NONE;
      o_Player_Position <= POS_W'(START_POS);
      o_Speed           <= '0;
    end else if (i_fTick) begin
      state             <= state_next;
      last_dir          <= dir;
      o_Player_Position <= pos_next;
      o_Speed           <= speed_next;
    end
  end

`ifdef PLAYER_MOTION_WRAP_EN
  assign o_Wall_Hit = 1'b0;
`else
  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      o_Wall_Hit <= 1'b0;
    else
      o_Wall_Hit <= i_fTick & advance & clamp;
  end
`endif

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: two instances (START_POS 108 and 2) against a tick-level reference model.
module tb_player_motion_ctrl;

  localparam int LIM    = 216;
  localparam int RANGE  = 217;
  localparam int MAXS   = 4;
  localparam int ACCEL  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ftick = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;

  logic [1:0][9:0] pos_o;
  logic [1:0][2:0] spd_o;
  logic [1:0]      mov_o;
  logic [1:0]      hit_o;

  int checks = 0;
  int failures = 0;

  int m_pos[2], m_spd[2], m_n[2], m_last[2];
  bit m_mov[2], m_blk[2], m_hit[2];

  always #5 clk = ~clk;

  player_motion_ctrl u_dut (
    .i_Clk (clk), .i_Rst (rst), .i_fTick (ftick),
    .i_Btn_Left (btn_left), .i_Btn_Right (btn_right),
    .o_Player_Position (pos_o[0]), .o_Speed (spd_o[0]),
    .o_Moving (mov_o[0]), .o_Wall_Hit (hit_o[0])
  );

  player_motion_ctrl #(.START_POS(2)) u_dut_lo (
    .i_Clk (clk), .i_Rst (rst), .i_fTick (ftick),
    .i_Btn_Left (btn_left), .i_Btn_Right (btn_right),
    .o_Player_Position (pos_o[1]), .o_Speed (spd_o[1]),
    .o_Moving (mov_o[1]), .o_Wall_Hit (hit_o[1])
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = (i == 0) ? 108 : 2;
      m_spd[i] = 0; m_n[i] = 0; m_last[i] = 0;
      m_mov[i] = 0; m_blk[i] = 0; m_hit[i] = 0;
    end
  endtask

  // Direction codes: 0 none, 1 left, 2 right.
  task automatic model_tick(input bit l, input bit r);
    int d, s, np;
    d = (l && !r) ? 1 : (r && !l) ? 2 : 0;
    for (int i = 0; i < 2; i++) begin
      m_hit[i] = 0;
      if (d == 0) begin
        m_spd[i] = 0; m_mov[i] = 0; m_blk[i] = 0; m_n[i] = 0;
      end else if (m_blk[i] && d == m_last[i]) begin
        m_spd[i] = 0;
      end else begin
        m_n[i] = (m_mov[i] && d == m_last[i]) ? m_n[i] + 1 : 1;
        s = 1 + (m_n[i] - 1) / ACCEL;
        if (s > MAXS) s = MAXS;
        np = (d == 1) ? m_pos[i] - s : m_pos[i] + s;
`ifdef PLAYER_MOTION_WRAP_EN
        if (np < 0) np = np + RANGE;
        else if (np >= RANGE) np = np - RANGE;
        m_pos[i] = np; m_spd[i] = s; m_mov[i] = 1; m_blk[i] = 0;
`else
        if (np < 0 || np > LIM) begin
          m_pos[i] = (np < 0) ? 0 : LIM;
          m_spd[i] = 0; m_mov[i] = 0; m_blk[i] = 1; m_hit[i] = 1;
        end else begin
          m_pos[i] = np; m_spd[i] = s; m_mov[i] = 1; m_blk[i] = 0;
        end
`endif
      end
      m_last[i] = d;
    end
  endtask

  task automatic cycle(input bit l, input bit r, input bit t, input bit rs);
    @(negedge clk);
    btn_left = l; btn_right = r; ftick = t; rst = rs;
    @(posedge clk);
    #1;
    ftick = 0; rst = 0;
    if (rs) model_reset();
    else if (t) model_tick(l, r);
    else for (int i = 0; i < 2; i++) m_hit[i] = 0;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pos_o[i], spd_o[i], mov_o[i], hit_o[i]} !== {((i == 0) ? 10'd108 : 10'd2), 3'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset[%0d] got pos=%0d spd=%0d mov=%0b hit=%0b exp pos=%0d spd=0 mov=0 hit=0",
                 i, pos_o[i], spd_o[i], mov_o[i], hit_o[i], (i == 0) ? 108 : 2);
      end
    end
  endtask

  task automatic test_ramp_right();
    cycle(0, 0, 0, 1);
    for (int k = 1; k <= 17; k++) begin
      cycle(0, 1, 1, 0);
      for (int g = $urandom_range(0, 3); g >= 0; g--) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if ({pos_o[i], spd_o[i], mov_o[i], hit_o[i]} !== {10'(m_pos[i]), 3'(m_spd[i]), m_mov[i], m_hit[i]}) begin
            failures++;
            $display("FAIL ramp[%0d] tick %0d got pos=%0d spd=%0d mov=%0b hit=%0b exp pos=%0d spd=%0d mov=%0b hit=%0b",
                     i, k, pos_o[i], spd_o[i], mov_o[i], hit_o[i], m_pos[i], m_spd[i], m_mov[i], m_hit[i]);
          end
        end
        if (g > 0) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0);
      end
    end
    checks++;
    if ({pos_o[0], spd_o[0], mov_o[0]} !== {10'd135, 3'd3, 1'b1}) begin
      failures++;
      $display("FAIL ramp17 got pos=%0d spd=%0d mov=%0b exp pos=135 spd=3 mov=1", pos_o[0], spd_o[0], mov_o[0]);
    end
    checks++;
    if (pos_o[1] !== 10'd29) begin
      failures++;
      $display("FAIL ramp17_lo got pos=%0d exp 29", pos_o[1]);
    end
  endtask

  task automatic test_cruise_release();
    cycle(0, 0, 0, 1);
    for (int k = 1; k <= 40; k++) begin
      cycle(0, 1, 1, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({pos_o[i], spd_o[i], mov_o[i], hit_o[i]} !== {10'(m_pos[i]), 3'(m_spd[i]), m_mov[i], m_hit[i]}) begin
          failures++;
          $display("FAIL cruise[%0d] tick %0d got pos=%0d spd=%0d mov=%0b hit=%0b exp pos=%0d spd=%0d mov=%0b hit=%0b",
                   i, k, pos_o[i], spd_o[i], mov_o[i], hit_o[i], m_pos[i], m_spd[i], m_mov[i], m_hit[i]);
        end
      end
      if (k == 24 || k == 25) begin
        checks++;
        if (spd_o[1] !== ((k == 24) ? 3'd3 : 3'd4)) begin
          failures++;
          $display("FAIL cruise_step tick %0d got spd=%0d exp %0d", k, spd_o[1], (k == 24) ? 3 : 4);
        end
      end
    end
    checks++;
    if ({pos_o[1], spd_o[1], mov_o[1]} !== {10'd114, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL cruise40 got pos=%0d spd=%0d mov=%0b exp pos=114 spd=4 mov=1", pos_o[1], spd_o[1], mov_o[1]);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if ({pos_o[1], spd_o[1], mov_o[1]} !== {10'd114, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL release got pos=%0d spd=%0d mov=%0b exp pos=114 spd=0 mov=0", pos_o[1], spd_o[1], mov_o[1]);
    end
  endtask

  task automatic test_wall();
    int exp_pos[3];
    bit exp_hit[3];
`ifdef PLAYER_MOTION_WRAP_EN
    exp_pos = '{1, 0, 216};
    exp_hit = '{0, 0, 0};
`else
    exp_pos = '{1, 0, 0};
    exp_hit = '{0, 0, 1};
`endif
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 1, 0);
      checks++;
      if ({pos_o[1], hit_o[1]} !== {10'(exp_pos[k]), exp_hit[k]}) begin
        failures++;
        $display("FAIL wall tick %0d got pos=%0d hit=%0b exp pos=%0d hit=%0b",
                 k + 1, pos_o[1], hit_o[1], exp_pos[k], exp_hit[k]);
      end
    end
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      cycle(k < 3, k >= 3, 1, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({pos_o[i], spd_o[i], mov_o[i], hit_o[i]} !== {10'(m_pos[i]), 3'(m_spd[i]), m_mov[i], m_hit[i]}) begin
          failures++;
          $display("FAIL wall_seq[%0d] step %0d got pos=%0d spd=%0d mov=%0b hit=%0b exp pos=%0d spd=%0d mov=%0b hit=%0b",
                   i, k, pos_o[i], spd_o[i], mov_o[i], hit_o[i], m_pos[i], m_spd[i], m_mov[i], m_hit[i]);
        end
      end
    end
`ifndef PLAYER_MOTION_WRAP_EN
    cycle(0, 0, 0, 1);
    cycle(1, 0, 1, 0); cycle(1, 0, 1, 0); cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    checks++;
    if (hit_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL wall_pulse_len got hit=%0b exp 0", hit_o[1]);
    end
    cycle(1, 0, 1, 0);
    checks++;
    if ({pos_o[1], spd_o[1], mov_o[1], hit_o[1]} !== {10'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL blocked_hold got pos=%0d spd=%0d mov=%0b hit=%0b exp pos=0 spd=0 mov=0 hit=0",
               pos_o[1], spd_o[1], mov_o[1], hit_o[1]);
    end
    cycle(0, 1, 1, 0);
    checks++;
    if ({pos_o[1], spd_o[1], mov_o[1]} !== {10'd1, 3'd1, 1'b1}) begin
      failures++;
      $display("FAIL blocked_exit got pos=%0d spd=%0d mov=%0b exp pos=1 spd=1 mov=1", pos_o[1], spd_o[1], mov_o[1]);
    end
`endif
  endtask

  task automatic test_both_and_reset();
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) cycle(1, 1, 1, 0);
    checks++;
    if ({pos_o[0], spd_o[0], mov_o[0]} !== {10'd108, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL both got pos=%0d spd=%0d mov=%0b exp pos=108 spd=0 mov=0", pos_o[0], spd_o[0], mov_o[0]);
    end
    for (int k = 0; k < 12; k++) cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    checks++;
    if ({pos_o[0], spd_o[0], mov_o[0]} !== {10'd108, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL rst_tick got pos=%0d spd=%0d mov=%0b exp pos=108 spd=0 mov=0", pos_o[0], spd_o[0], mov_o[0]);
    end
    cycle(0, 1, 1, 0);
    checks++;
    if ({pos_o[0], spd_o[0], mov_o[0]} !== {10'd109, 3'd1, 1'b1}) begin
      failures++;
      $display("FAIL rst_restart got pos=%0d spd=%0d mov=%0b exp pos=109 spd=1 mov=1", pos_o[0], spd_o[0], mov_o[0]);
    end
  endtask

  task automatic test_random();
    bit l, r, t, rs;
    int pick;
    cycle(0, 0, 0, 1);
    l = 0; r = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        pick = $urandom_range(0, 3);
        l = pick[0]; r = pick[1];
      end
      t  = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 299) == 0);
      cycle(l, r, t, rs);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({pos_o[i], spd_o[i], mov_o[i], hit_o[i]} !== {10'(m_pos[i]), 3'(m_spd[i]), m_mov[i], m_hit[i]}) begin
          failures++;
          $display("FAIL random[%0d] cyc %0d got pos=%0d spd=%0d mov=%0b hit=%0b exp pos=%0d spd=%0d mov=%0b hit=%0b",
                   i, c, pos_o[i], spd_o[i], mov_o[i], hit_o[i], m_pos[i], m_spd[i], m_mov[i], m_hit[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp_right();
    test_cruise_release();
    test_wall();
    test_both_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
